// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, receive FSM state type and byte-select helpers.
// Used by udp_pkt_recv; CRC_RESIDUE only matters when UDP_RX_CRC_EN is defined.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
   localparam logic [7:0]  ETH_SFD        = 8'hD5;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam int unsigned ETH_HDR_LEN    = 14;
   localparam int unsigned IP_HDR_LEN     = 20;
   localparam int unsigned UDP_HDR_LEN    = 8;
   localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;
   localparam int unsigned CNT_W          = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_ETH_HDR,
      ST_IP_HDR,
      ST_UDP_HDR,
      ST_PAYLOAD,
      ST_CHECK_FCS,
      ST_DONE,
      ST_DROP
   } rx_state_e;

   // Byte idx of a 48-bit field, most significant byte first (wire order).
   function automatic logic [7:0] sel_byte48(input logic [47:0] v, input logic [2:0] idx);
      logic [47:0] t;
      t = v << {idx, 3'b000};
      return t[47:40];
   endfunction

   function automatic logic [7:0] sel_byte32(input logic [31:0] v, input logic [1:0] idx);
      logic [31:0] t;
      t = v << {idx, 3'b000};
      return t[31:24];
   endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one byte (LSB first).
module eth_crc32_byte (
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c = (c >> 1) ^ ((c[0] ^ data[i]) ? 32'hEDB88320 : 32'h0000_0000);
      end
      crc_out = c;
   end

endmodule

// File: rtl/udp_pkt_recv.sv
// GMII byte-stream parser: delivers UDP payload addressed to this node/port plus sender fields.
// Optional FCS check with `define UDP_RX_CRC_EN (done/err then follow the end of frame).
module udp_pkt_recv
   import eth_pkg::*;
#(
   parameter logic [15:0] LISTEN_PORT = 16'd50000,
   parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_data,
   input  logic        i_data_vl,
   input  logic [47:0] i_self_mac,
   input  logic [31:0] i_self_ip,
   output logic [7:0]  o_data,
   output logic        o_data_vl,
   output logic        o_sop,
   output logic        o_eop,
   output logic [47:0] o_src_mac,
   output logic [31:0] o_src_ip,
   output logic [15:0] o_src_port,
   output logic [15:0] o_len,
   output logic        o_pkt_done,
   output logic        o_pkt_err
);

`ifdef UDP_RX_CRC_EN
   localparam rx_state_e END_ST = ST_CHECK_FCS;
`else
   localparam rx_state_e END_ST = ST_DONE;
`endif

   rx_state_e        state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_inc_c;
   logic             ucast_ok, bcast_ok, ucast_ok_d, bcast_ok_d;
   logic [47:0]      src_mac_s;
   logic [31:0]      src_ip_s;
   logic [15:0]      src_port_s, len_s;
   logic [15:0]      udp_len_c;
   logic             len_ok_c;
   logic             pay_vl_c, sop_c, eop_c, done_c, err_c, publish_c;
   logic             crc_ok_c;

   assign cnt_inc_c = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   assign udp_len_c = {len_s[7:0], i_data};
   assign len_ok_c  = (udp_len_c >= 16'(UDP_HDR_LEN)) &&
                      (udp_len_c <= MAX_PAYLOAD + 16'(UDP_HDR_LEN));

`ifdef UDP_RX_CRC_EN
   logic [31:0] crc, crc_next;

   eth_crc32_byte u_crc (.crc_in(crc), .data(i_data), .crc_out(crc_next));

   assign crc_ok_c = ({<<{crc}} == CRC_RESIDUE);

   // CRC restarts on SFD and covers dst MAC through FCS.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc <= '1;
      end else if (state == ST_PREAMBLE && i_data == ETH_SFD) begin
         crc <= '1;
      end else if (i_data_vl && (state inside {ST_ETH_HDR, ST_IP_HDR, ST_UDP_HDR,
                                               ST_PAYLOAD, ST_CHECK_FCS})) begin
         crc <= crc_next;
      end
   end
`else
   assign crc_ok_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ucast_ok <= 1'b0;
         bcast_ok <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         ucast_ok <= ucast_ok_d;
         bcast_ok <= bcast_ok_d;
      end
   end

   // Header fields are checked on the byte they arrive; any mismatch parks in DROP.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      ucast_ok_d = ucast_ok;
      bcast_ok_d = bcast_ok;
      pay_vl_c   = 1'b0;
      sop_c      = 1'b0;
      eop_c      = 1'b0;
      done_c     = 1'b0;
      err_c      = 1'b0;
      publish_c  = 1'b0;
      if (!i_data_vl) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         if (state == ST_PAYLOAD) err_c = 1'b1;
         if (state == ST_DONE) done_c = 1'b1;
         if (state == ST_CHECK_FCS) begin
            done_c = crc_ok_c;
            err_c  = !crc_ok_c;
         end
      end else begin
         case (state)
            ST_IDLE: state_d = (i_data == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
            ST_PREAMBLE: begin
               if (i_data == ETH_SFD) begin
                  state_d = ST_ETH_HDR;
                  cnt_d   = '0;
               end else if (i_data != ETH_PREAMBLE) begin
                  state_d = ST_DROP;
               end
            end
            ST_ETH_HDR: begin
               cnt_d = cnt_inc_c;
               if (cnt < 16'd6) begin
                  ucast_ok_d = (cnt == '0 || ucast_ok) && (i_data == sel_byte48(i_self_mac, cnt[2:0]));
                  bcast_ok_d = (cnt == '0 || bcast_ok) && (i_data == 8'hFF);
                  if (!ucast_ok_d && !bcast_ok_d) state_d = ST_DROP;
               end else if (cnt == 16'd12) begin
                  if (i_data != ETHERTYPE_IPV4[15:8]) state_d = ST_DROP;
               end else if (cnt == 16'(ETH_HDR_LEN - 1)) begin
                  if (i_data != ETHERTYPE_IPV4[7:0]) begin
                     state_d = ST_DROP;
                  end else begin
                     state_d = ST_IP_HDR;
                     cnt_d   = '0;
                  end
               end
            end
            ST_IP_HDR: begin
               cnt_d = cnt_inc_c;
               case (cnt)
                  16'd0:  if (i_data != 8'h45) state_d = ST_DROP;
                  16'd6:  if ((i_data & 8'hBF) != 8'h00) state_d = ST_DROP;
                  16'd7:  if (i_data != 8'h00) state_d = ST_DROP;
                  16'd9:  if (i_data != IP_PROTO_UDP) state_d = ST_DROP;
                  16'd16, 16'd17, 16'd18:
                     if (i_data != sel_byte32(i_self_ip, cnt[1:0])) state_d = ST_DROP;
                  16'(IP_HDR_LEN - 1): begin
                     if (i_data != sel_byte32(i_self_ip, cnt[1:0])) begin
                        state_d = ST_DROP;
                     end else begin
                        state_d = ST_UDP_HDR;
                        cnt_d   = '0;
                     end
                  end
                  default: ;
               endcase
            end
            ST_UDP_HDR: begin
               cnt_d = cnt_inc_c;
               case (cnt)
                  16'd2: if (i_data != LISTEN_PORT[15:8]) state_d = ST_DROP;
                  16'd3: if (i_data != LISTEN_PORT[7:0]) state_d = ST_DROP;
                  16'd5: if (!len_ok_c) state_d = ST_DROP;
                  16'(UDP_HDR_LEN - 1): begin
                     publish_c = 1'b1;
                     cnt_d     = '0;
                     state_d   = (len_s == 16'd0) ? END_ST : ST_PAYLOAD;
                  end
                  default: ;
               endcase
            end
            ST_PAYLOAD: begin
               pay_vl_c = 1'b1;
               sop_c    = (cnt == '0);
               eop_c    = (cnt == len_s - 16'd1);
               cnt_d    = cnt_inc_c;
               if (eop_c) state_d = END_ST;
            end
            ST_DONE: begin
               done_c  = 1'b1;
               state_d = ST_DROP;
            end
            ST_CHECK_FCS: state_d = ST_CHECK_FCS;
            ST_DROP:      state_d = ST_DROP;
            default:      state_d = ST_DROP;
         endcase
      end
   end

   // Shadow capture of sender fields and registered payload/status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_mac_s  <= '0;
         src_ip_s   <= '0;
         src_port_s <= '0;
         len_s      <= '0;
         o_data     <= '0;
         o_data_vl  <= 1'b0;
         o_sop      <= 1'b0;
         o_eop      <= 1'b0;
         o_pkt_done <= 1'b0;
         o_pkt_err  <= 1'b0;
         o_src_mac  <= '0;
         o_src_ip   <= '0;
         o_src_port <= '0;
         o_len      <= '0;
      end else begin
         if (i_data_vl) begin
            if (state == ST_ETH_HDR && cnt >= 16'd6 && cnt < 16'd12)
               src_mac_s <= {src_mac_s[39:0], i_data};
            if (state == ST_IP_HDR && cnt >= 16'd12 && cnt < 16'd16)
               src_ip_s <= {src_ip_s[23:0], i_data};
            if (state == ST_UDP_HDR && cnt < 16'd2)
               src_port_s <= {src_port_s[7:0], i_data};
            if (state == ST_UDP_HDR && cnt == 16'd4)
               len_s <= {8'h00, i_data};
            if (state == ST_UDP_HDR && cnt == 16'd5)
               len_s <= udp_len_c - 16'(UDP_HDR_LEN);
         end
         o_data     <= pay_vl_c ? i_data : 8'h00;
         o_data_vl  <= pay_vl_c;
         o_sop      <= sop_c;
         o_eop      <= eop_c;
         o_pkt_done <= done_c;
         o_pkt_err  <= err_c;
         if (publish_c) begin
            o_src_mac  <= src_mac_s;
            o_src_ip   <= src_ip_s;
            o_src_port <= src_port_s;
            o_len      <= len_s;
         end
      end
   end

endmodule
